// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch and data ports.
// Data has priority; a starvation guard and a data lock shape the grants.
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDRSIZE     = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDRSIZE-1:0] i_addr,
  output logic                i_gnt,
  output logic [WIDTH-1:0]    i_rdata,
  output logic                i_rvalid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDRSIZE-1:0] d_addr,
  input  logic [WIDTH-1:0]    d_wdata,
  input  logic                d_lock,
  output logic                d_gnt,
  output logic [WIDTH-1:0]    d_rdata,
  output logic                d_rvalid,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic [3:0]          starve_cnt
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]          starve_q, starve_d;
  logic                own_v_q, own_d_q;
  logic [ADDRSIZE-1:0] addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [WIDTH-1:0]    irdata_q, drdata_q;
  logic                sat;

  assign sat = (starve_q == LIM);

  // Per-cycle grant: lock, then starvation guard, then data, then fetch.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (d_lock) begin
        d_gnt = d_req;
      end else if (sat && i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // SRAM side: winner drives the bus, otherwise address/data hold.
  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
      mem_wdata = '0;
    end
  end

  // Starvation counter next state.
  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_lock) begin
      starve_d = starve_q;
    end else if (d_gnt && !sat) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Read return routing from the owner tag captured at grant.
  always_comb begin
    i_rvalid = own_v_q & ~own_d_q;
    d_rvalid = own_v_q & own_d_q;
    i_rdata  = i_rvalid ? mem_rdata : irdata_q;
    d_rdata  = d_rvalid ? mem_rdata : drdata_q;
  end

  assign starve_cnt = starve_q;

  // State: held bus values, owner tag, last returned data, counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      own_v_q  <= 1'b0;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      own_v_q  <= mem_en & ~mem_we;
      own_d_q  <= d_gnt;
      if (mem_en) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (i_rvalid) irdata_q <= mem_rdata;
      if (d_rvalid) drdata_q <= mem_rdata;
    end
  end

endmodule
